// File: rtl/req_ack_pkg.sv
// Shared types and helpers for the round-robin req/ack controller.
// State encoding, index widths and delay counter width live here.
package req_ack_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        DRAIN
    } req_ack_state_e;

    localparam int ACK_DELAY_MAX = 255;
    localparam int DLY_W = $clog2(ACK_DELAY_MAX + 1);

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int tmo_w(input int t);
        return (t > 1) ? $clog2(t) : 1;
    endfunction

endpackage

// File: rtl/req_ack_rr_ctrl_if.sv
// Requester-side bundle of the req/ack controller.
// master = requesters, slave = controller.
interface req_ack_rr_ctrl_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);

    localparam int IW = req_ack_pkg::ch_w(NUM_CH);

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] ack;
    logic [NUM_CH-1:0] err;
    logic              busy;
    logic [IW-1:0]     grant_id;
    logic [CNT_W-1:0]  txn_cnt;

    modport master (
        output req,
        input  ack,
        input  err,
        input  busy,
        input  grant_id,
        input  txn_cnt
    );

    modport slave (
        input  req,
        output ack,
        output err,
        output busy,
        output grant_id,
        output txn_cnt
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after last_i.
// Search starts at last_i+1 and wraps at N-1.
module rr_arbiter
    import req_ack_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = ch_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic          hit;
    logic [IW-1:0] cand;

    // Scan channels in rotating priority order, keep the first hit.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        hit   = 1'b0;
        cand  = '0;
        for (int i = 1; i <= N; i++) begin
            cand = IW'((int'(last_i) + i) % N);
            if (en_i && !hit && req_i[cand]) begin
                hit         = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/req_ack_rr_ctrl.sv
// Multi-channel four-phase req/ack controller with round-robin,
// programmable ack delay and ack-hold timeout.
module req_ack_rr_ctrl
    import req_ack_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int ACK_DELAY = 2,
    parameter int TIMEOUT   = 16,
    parameter int CNT_W     = 16
) (
    input logic              clk,
    input logic              rst,
    req_ack_rr_ctrl_if.slave bus
);

    localparam int IW = ch_w(NUM_CH);
    localparam int HW = tmo_w(TIMEOUT);

    localparam logic [DLY_W-1:0] DLY_LOAD =
        DLY_W'(ACK_DELAY - 1);
    localparam logic [HW-1:0] HOLD_LAST =
        HW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IW-1:0] LAST_RST =
        IW'(NUM_CH - 1);

    req_ack_state_e    state_q, state_d;
    logic [DLY_W-1:0]  dly_q, dly_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [IW-1:0]     gid_q, gid_d;
    logic [IW-1:0]     last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_CH-1:0] err_q, err_d;

    logic [NUM_CH-1:0] arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              req_cur;

    assign req_cur = bus.req[gid_q];

    rr_arbiter #(
        .N (NUM_CH)
    ) u_arb (
        .req_i  (bus.req),
        .last_i (last_q),
        .en_i   (state_q == IDLE),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    // State, counters and pointers; reset drops ack at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            dly_q   <= '0;
            hold_q  <= '0;
            gid_q   <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            hold_q  <= hold_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next state: release/abort beats delay expiry and timeout.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        hold_d  = hold_q;
        gid_d   = gid_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    state_d = WAIT;
                    gid_d   = arb_idx;
                    last_d  = arb_idx;
                    dly_d   = DLY_LOAD;
                end
            end
            WAIT: begin
                if (!req_cur) begin
                    state_d = IDLE;
                end else if (dly_q == '0) begin
                    state_d = ACK;
                    hold_d  = '0;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            ACK: begin
                if (!req_cur) begin
                    state_d = IDLE;
                    cnt_d   = cnt_q + 1'b1;
                end else if (TIMEOUT != 0 &&
                             hold_q == HOLD_LAST) begin
                    state_d      = DRAIN;
                    err_d[gid_q] = 1'b1;
                end else if (TIMEOUT != 0) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!req_cur) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.ack      = (state_q == ACK) ?
                          (NUM_CH'(1) << gid_q) : '0;
    assign bus.grant_id = gid_q;
    assign bus.err      = err_q;
    assign bus.txn_cnt  = cnt_q;

endmodule

// File: tb/tb_req_ack_rr_ctrl.sv
// Directed bench for req_ack_rr_ctrl with a timestamp-based
// reference model checked every cycle.
module tb_req_ack_rr_ctrl;

    localparam int N   = 4;
    localparam int D   = 2;
    localparam int TMO = 4;
    localparam int CW  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    req_ack_rr_ctrl_if #(
        .NUM_CH (N),
        .CNT_W  (CW)
    ) bus ();

    req_ack_rr_ctrl #(
        .NUM_CH    (N),
        .ACK_DELAY (D),
        .TIMEOUT   (TMO),
        .CNT_W     (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h",
                     nm, act, exp);
        end
    endtask

    // Reference model: tracks served channel and the edge
    // numbers at which it was granted and acknowledged.
    int e, m_ch, m_last, m_cnt, gnt_e, ack_e, err_ch, mc;
    bit drain;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            e = 0; m_ch = -1; m_last = N - 1; m_cnt = 0;
            gnt_e = 0; ack_e = -1; err_ch = -1; drain = 0;
        end else begin
            e++;
            err_ch = -1;
            if (m_ch < 0) begin
                for (int k = 1; k <= N; k++) begin
                    mc = (m_last + k) % N;
                    if (m_ch < 0 && bus.req[mc]) m_ch = mc;
                end
                if (m_ch >= 0) begin
                    m_last = m_ch; gnt_e = e;
                    ack_e = -1; drain = 0;
                end
            end else if (!bus.req[m_ch]) begin
                if (ack_e >= 0 && !drain)
                    m_cnt = (m_cnt + 1) % (1 << CW);
                m_ch = -1;
            end else if (ack_e < 0) begin
                if (e - gnt_e == D) ack_e = e;
            end else if (!drain && e - ack_e == TMO) begin
                drain = 1;
                err_ch = m_ch;
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("busy", bus.busy, m_ch >= 0);
            chk("ack", bus.ack,
                (m_ch >= 0 && ack_e >= 0 && !drain) ?
                (32'd1 << m_ch) : 32'd0);
            chk("err", bus.err,
                (err_ch >= 0) ? (32'd1 << err_ch) : 32'd0);
            chk("txn_cnt", bus.txn_cnt, m_cnt);
            if (m_ch >= 0)
                chk("grant_id", bus.grant_id, m_ch);
            chk("ack_onehot", $countones(bus.ack) <= 1, 1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req = '0;
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic wait_ack(input string nm);
        int n = 0;
        while (bus.ack == '0 && n < 20) begin
            tick(1);
            n++;
        end
        if (bus.ack == '0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: no ack within 20 cycles", nm);
        end
    endtask

    int hold_n;
    int ch;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        bus.req = '0;
        tick(2);
        chk("rst_ack", bus.ack, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_gid", bus.grant_id, 0);
        chk("rst_txn", bus.txn_cnt, 0);
        rst = 1'b1;
        tick(2);

        // single request, release coincides with timeout edge
        bus.req = 4'b0100;
        tick(1);
        chk("s_busy", bus.busy, 1);
        chk("s_gid", bus.grant_id, 2);
        chk("s_ack0", bus.ack, 0);
        tick(1);
        chk("s_ack1", bus.ack, 0);
        tick(1);
        chk("s_ack2", bus.ack, 4'b0100);
        tick(3);
        chk("s_ack_hold", bus.ack, 4'b0100);
        bus.req = '0;
        tick(1);
        chk("s_rel_ack", bus.ack, 0);
        chk("s_rel_txn", bus.txn_cnt, 1);
        chk("s_rel_busy", bus.busy, 0);
        tick(1);
        chk("s_rel_err", bus.err, 0);

        // round-robin with all channels requesting
        do_reset();
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            ch = k % N;
            wait_ack("rr_wait");
            chk("rr_order", bus.ack, 32'd1 << ch);
            tick(1);
            bus.req[ch] = 1'b0;
            tick(1);
            chk("rr_rel", bus.ack, 0);
            if (k < 4) bus.req[ch] = 1'b1;
            else bus.req = '0;
        end
        tick(2);
        chk("rr_txn", bus.txn_cnt, 5);

        // abort during delay, then arbitration after ch1
        do_reset();
        bus.req = 4'b0010;
        tick(1);
        chk("ab_busy", bus.busy, 1);
        chk("ab_gid", bus.grant_id, 1);
        bus.req = '0;
        tick(1);
        chk("ab_idle", bus.busy, 0);
        chk("ab_ack", bus.ack, 0);
        tick(1);
        chk("ab_txn", bus.txn_cnt, 0);
        bus.req = 4'b0011;
        wait_ack("ab_wait");
        chk("ab_next", bus.ack, 4'b0001);
        bus.req = '0;
        tick(2);
        chk("ab_txn2", bus.txn_cnt, 1);

        // ack-hold timeout on channel 3
        do_reset();
        bus.req = 4'b1000;
        tick(1);
        chk("to_gid", bus.grant_id, 3);
        tick(2);
        hold_n = 0;
        while (bus.ack[3] && hold_n < 20) begin
            hold_n++;
            tick(1);
        end
        chk("to_ack_cycles", hold_n, TMO);
        chk("to_err", bus.err, 4'b1000);
        chk("to_busy", bus.busy, 1);
        tick(1);
        chk("to_err_pulse", bus.err, 0);
        tick(2);
        chk("to_drain_busy", bus.busy, 1);
        chk("to_drain_ack", bus.ack, 0);
        bus.req = '0;
        tick(1);
        chk("to_idle", bus.busy, 0);
        chk("to_txn", bus.txn_cnt, 0);

        // asynchronous reset while acknowledging
        do_reset();
        bus.req = 4'b0001;
        tick(3);
        chk("ra_ack", bus.ack, 4'b0001);
        #2 rst = 1'b0;
        #1;
        chk("ra_ack_drop", bus.ack, 0);
        chk("ra_busy", bus.busy, 0);
        chk("ra_err", bus.err, 0);
        bus.req = 4'b0011;
        #3 rst = 1'b1;
        tick(1);
        chk("ra_gid", bus.grant_id, 0);
        wait_ack("ra_wait");
        chk("ra_first", bus.ack, 4'b0001);
        bus.req = '0;
        tick(2);

        // counter wrap with a 3-bit txn_cnt
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            bus.req = 4'b0010;
            wait_ack("wr_wait");
            bus.req = '0;
            tick(1);
            if (i == 8) chk("wr_zero", bus.txn_cnt, 0);
            tick(1);
        end
        chk("wr_one", bus.txn_cnt, 1);

        $display("Result: errors=%0d of %0d checks",
                 n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/req_ack_rr_ctrl.md
# req_ack_rr_ctrl

Multi-channel four-phase request/acknowledge controller: it serves `NUM_CH` independent requesters one at a time, with round-robin fairness, a programmable request-to-acknowledge delay and an acknowledge-hold timeout. It is the parametrised successor to the team's single-channel `dut(clk, rst, req, ack)` handshake responder. It sits between the request sources and the shared resource whose service it sequences.

## Interface
- `NUM_CH`, 4: number of requester channels (2..16).
- `ACK_DELAY`, 2: cycles from the grant edge to `ack` high (1..255).
- `TIMEOUT`, 16: maximum cycles `ack` may stay high awaiting `req` release; 0 disables the timeout.
- `CNT_W`, 16: width of the completed-transaction counter.
- `clk` input 1: single clock; all logic samples on posedge.
- `rst` input 1: reset, asynchronous assert, active-low; synchronous release.
- `req` input `NUM_CH`: level request per channel.
- `ack` output `NUM_CH`: level acknowledge per channel; at most one bit is high at any time.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `grant_id` output `$clog2(NUM_CH)`: index of the channel being served; valid while `busy`.
- `err` output `NUM_CH`: one-cycle pulse on the channel whose acknowledge timed out.
- `txn_cnt` output `CNT_W`: count of completed handshakes; wraps modulo 2^`CNT_W`.

## Operation
- FSM states:
  - IDLE: no channel is being served.
  - WAIT: the delay counter is running.
  - ACK: `ack[grant_id]` is high.
  - DRAIN: a timeout has occurred and the block waits for `req` to fall.
- IDLE → WAIT: any `req` bit is high at an edge.
  - The round-robin arbiter picks the first requesting channel after `last_grant`, wrapping at `NUM_CH`-1.
  - `grant_id` and `last_grant` are updated on that edge.
  - The delay counter is loaded with `ACK_DELAY`-1.
- WAIT → ACK: the delay counter reaches 0 while `req[grant_id]` is still high. `ack[grant_id]` is set and the hold counter is cleared.
- WAIT → IDLE (abort): `req[grant_id]` is sampled low. No ack is given, `txn_cnt` is unchanged, and `last_grant` keeps the aborted channel.
- ACK → IDLE: `req[grant_id]` is sampled low. `ack` is cleared and `txn_cnt` increments by 1.
- ACK → DRAIN: `TIMEOUT` != 0, the hold counter reaches `TIMEOUT`, and `req` is still high. `ack` is cleared, `err[grant_id]` pulses for one cycle, and `txn_cnt` is unchanged.
- DRAIN → IDLE: `req[grant_id]` is sampled low.
- Requests on other channels are ignored until the FSM returns to IDLE; they are never dropped, only delayed.
- The arbiter is fed only in IDLE; `req` changes in other states do not affect `grant_id`.

## Timing
- Reset values:
  - `ack`=0, `err`=0, `busy`=0, `grant_id`=0, `txn_cnt`=0.
  - FSM in IDLE, `last_grant`=`NUM_CH`-1, so channel 0 wins first.
- Reset asserted mid-transaction drops `ack` immediately (asynchronous) with no `err` pulse.
- Grant latency: `req` is high at edge T, so `busy` is high after T and `ack` is high after edge T+`ACK_DELAY`.
- Release latency: `req` is sampled low at edge R, so `ack` is low and `txn_cnt` is updated after R.
- After any return to IDLE there is at least one IDLE cycle; the next grant occurs at the following edge at the earliest.
- Timeout: `ack` is high for exactly `TIMEOUT` cycles. `err` is high for the cycle immediately after `ack` falls.
- Simultaneous events:
  - Release and timeout at the same edge: the release wins, counting as success with no `err`.
  - Abort and delay expiry at the same edge: the abort wins.
- `txn_cnt` at 2^`CNT_W`-1 wraps to 0 with no flag.

## Structure
- Package `req_ack_pkg` holds:
  - the state typedef `req_ack_state_e` (IDLE, WAIT, ACK, DRAIN);
  - the channel-index width function;
  - the localparams derived from `ACK_DELAY` and `TIMEOUT` counter widths.
- Sub-module `rr_arbiter` (parameter `N`):
  - inputs: `req` vector, `last` pointer, `en`;
  - outputs: one-hot grant and encoded index;
  - purely combinational.
- The top level holds the FSM, the delay and hold counters, `txn_cnt` and the `last_grant` register.

## Test plan
- Reset then single request (defaults): `req[2]` rises at edge 5 and falls 3 cycles after `ack`. Required: `ack[2]` high after edge 7, low one edge after `req` falls, `txn_cnt`=1.
- Round-robin: `req`=4'b1111 held, each channel releases 1 cycle after its ack. Required grant order 0,1,2,3,0; `txn_cnt`=5; never two `ack` bits high.
- Abort: `req[1]` rises and falls after 1 cycle with `ACK_DELAY`=2. Required: `ack` never high, `txn_cnt`=0, next `req`=4'b0011 is granted to channel 0.
- Timeout: `TIMEOUT`=4, `req[3]` held high. Required: `ack[3]` high for exactly 4 cycles, then `err[3]` is a 1-cycle pulse, `busy` stays high until `req[3]` falls, `txn_cnt` unchanged.
- Reset mid-ACK: `rst` is driven low while `ack[0]`=1. Required: `ack` is 0 immediately, with no waiting for the clock edge. After release, the first grant goes to channel 0.
- Wrap: `CNT_W`=3 with 9 complete handshakes. Required `txn_cnt`=1.
